// File: rtl/intersection_fsm_if.sv
// Handshake bundle between the intersection sequencer and its driver/observer.
// Master drives tick/requests/hold; the sequencer (slave) returns phase status.
interface intersection_fsm_if;
  logic       tick;
  logic [1:0] left_req;
  logic       hold;
  logic [2:0] state;
  logic [3:0] remaining;
  logic       state_change;
  logic [1:0] left_pending;

  modport master (
    output tick, left_req, hold,
    input  state, remaining, state_change, left_pending
  );

  modport slave (
    input  tick, left_req, hold,
    output state, remaining, state_change, left_pending
  );
endinterface

// File: rtl/intersection_fsm.sv
// Eight-phase four-way intersection sequencer stepped by a 1 Hz tick.
// Left-arrow phases are inserted only when a turn request is pending.
module intersection_fsm #(
  parameter int T_GREEN  = 8,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_LEFT   = 4
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  intersection_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    PH_NS_GRN   = 3'd0,
    PH_NS_YEL   = 3'd1,
    PH_ALLRED_N = 3'd2,
    PH_EW_LEFT  = 3'd3,
    PH_EW_GRN   = 3'd4,
    PH_EW_YEL   = 3'd5,
    PH_ALLRED_E = 3'd6,
    PH_NS_LEFT  = 3'd7
  } phase_e;

  // Out-of-range dwells are clamped so remaining never reaches 0.
  function automatic logic [3:0] clamp_dwell(input int v);
    if (v < 1)       return 4'd1;
    else if (v > 15) return 4'd15;
    else             return 4'(v);
  endfunction

  localparam logic [3:0] D_GREEN  = clamp_dwell(T_GREEN);
  localparam logic [3:0] D_YELLOW = clamp_dwell(T_YELLOW);
  localparam logic [3:0] D_ALLRED = clamp_dwell(T_ALLRED);
  localparam logic [3:0] D_LEFT   = clamp_dwell(T_LEFT);

  function automatic logic [3:0] dwell(input phase_e p);
    case (p)
      PH_NS_GRN, PH_EW_GRN:     return D_GREEN;
      PH_NS_YEL, PH_EW_YEL:     return D_YELLOW;
      PH_ALLRED_N, PH_ALLRED_E: return D_ALLRED;
      default:                  return D_LEFT;
    endcase
  endfunction

  phase_e     state_q, state_d, next_ph;
  logic [3:0] remaining_q, remaining_d;
  logic       state_change_q, state_change_d;
  logic [1:0] left_pending_q, left_pending_d;
  logic [1:0] want_left, own_phase;
  logic       eff_tick;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q        <= PH_NS_GRN;
      remaining_q    <= D_GREEN;
      state_change_q <= 1'b0;
      left_pending_q <= 2'b00;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      state_change_q <= state_change_d;
      left_pending_q <= left_pending_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    state_change_d = 1'b0;
    next_ph        = state_q;
    eff_tick       = bus.tick & ~bus.hold;
    // A request arriving in the deciding cycle still earns its left arrow.
    want_left      = left_pending_q | bus.left_req;
    own_phase      = {state_q == PH_EW_LEFT, state_q == PH_NS_LEFT};

    case (state_q)
      PH_NS_GRN:   next_ph = PH_NS_YEL;
      PH_NS_YEL:   next_ph = PH_ALLRED_N;
      PH_ALLRED_N: next_ph = want_left[1] ? PH_EW_LEFT : PH_EW_GRN;
      PH_EW_LEFT:  next_ph = PH_EW_GRN;
      PH_EW_GRN:   next_ph = PH_EW_YEL;
      PH_EW_YEL:   next_ph = PH_ALLRED_E;
      PH_ALLRED_E: next_ph = want_left[0] ? PH_NS_LEFT : PH_NS_GRN;
      PH_NS_LEFT:  next_ph = PH_NS_GRN;
      default:     next_ph = PH_NS_GRN;
    endcase

    if (eff_tick) begin
      if (remaining_q == 4'd1) begin
        state_d        = next_ph;
        remaining_d    = dwell(next_ph);
        state_change_d = 1'b1;
      end else begin
        remaining_d = remaining_q - 4'd1;
      end
    end

    left_pending_d = left_pending_q | (bus.left_req & ~own_phase);
    if (state_change_d && state_d == PH_EW_LEFT) left_pending_d[1] = 1'b0;
    if (state_change_d && state_d == PH_NS_LEFT) left_pending_d[0] = 1'b0;
  end

  assign bus.state        = state_q;
  assign bus.remaining    = remaining_q;
  assign bus.state_change = state_change_q;
  assign bus.left_pending = left_pending_q;

endmodule

// File: tb/tb_intersection_fsm.sv
// Directed bench for intersection_fsm with default dwells (8/3/1/4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_intersection_fsm;
  logic CLOCK_50 = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   sc_total = 0;
  logic seen_left = 1'b0;

  intersection_fsm_if bus ();

  intersection_fsm dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(negedge CLOCK_50) begin
    if (resetn && bus.state_change) sc_total <= sc_total + 1;
    if (resetn && (bus.state == 3'd3 || bus.state == 3'd7)) seen_left <= 1'b1;
  end

  task automatic do_tick();
    @(negedge CLOCK_50) bus.tick = 1'b1;
    @(negedge CLOCK_50) bus.tick = 1'b0;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    bus.tick = 1'b0; bus.left_req = 2'b00; bus.hold = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    checks++;
    if (bus.state !== 3'd0 || bus.remaining !== 4'd8 || bus.state_change !== 1'b0 || bus.left_pending !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: got st=%0d rem=%0d sc=%b lp=%b, want st=0 rem=8 sc=0 lp=00",
               bus.state, bus.remaining, bus.state_change, bus.left_pending);
    end
    resetn = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic test_default_cycle();
    int sc_base;
    logic [2:0] exp_st;
    logic [3:0] exp_rem;
    logic chk;
    sc_base = sc_total;
    seen_left = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      do_tick();
      chk = 1'b1;
      case (k)
        1:  begin exp_st = 3'd0; exp_rem = 4'd7; end
        7:  begin exp_st = 3'd0; exp_rem = 4'd1; end
        8:  begin exp_st = 3'd1; exp_rem = 4'd3; end
        11: begin exp_st = 3'd2; exp_rem = 4'd1; end
        12: begin exp_st = 3'd4; exp_rem = 4'd8; end
        20: begin exp_st = 3'd5; exp_rem = 4'd3; end
        23: begin exp_st = 3'd6; exp_rem = 4'd1; end
        24: begin exp_st = 3'd0; exp_rem = 4'd8; end
        default: begin exp_st = 3'd0; exp_rem = 4'd0; chk = 1'b0; end
      endcase
      if (chk) begin
        checks++;
        if (bus.state !== exp_st || bus.remaining !== exp_rem) begin
          errors++;
          $display("FAIL default_tick%0d: got st=%0d rem=%0d, want st=%0d rem=%0d",
                   k, bus.state, bus.remaining, exp_st, exp_rem);
        end
      end
    end
    @(negedge CLOCK_50);
    checks++;
    if (sc_total - sc_base !== 6) begin
      errors++;
      $display("FAIL default_pulses: got %0d state_change pulses, want 6", sc_total - sc_base);
    end
    checks++;
    if (seen_left !== 1'b0) begin
      errors++;
      $display("FAIL default_no_left: left phase appeared=%b, want 0", seen_left);
    end
  endtask

  task automatic test_ew_left();
    @(negedge CLOCK_50) bus.left_req = 2'b10;
    @(negedge CLOCK_50) bus.left_req = 2'b00;
    checks++;
    if (bus.left_pending !== 2'b10) begin
      errors++;
      $display("FAIL ew_latch: got lp=%b, want 10", bus.left_pending);
    end
    do_ticks(11);
    checks++;
    if (bus.state !== 3'd2 || bus.left_pending !== 2'b10) begin
      errors++;
      $display("FAIL ew_hold_latch: got st=%0d lp=%b, want st=2 lp=10", bus.state, bus.left_pending);
    end
    do_tick();
    checks++;
    if (bus.state !== 3'd3 || bus.remaining !== 4'd4 || bus.left_pending !== 2'b00 || bus.state_change !== 1'b1) begin
      errors++;
      $display("FAIL ew_enter_left: got st=%0d rem=%0d lp=%b sc=%b, want st=3 rem=4 lp=00 sc=1",
               bus.state, bus.remaining, bus.left_pending, bus.state_change);
    end
  endtask

  task automatic test_own_phase();
    bus.left_req = 2'b10;
    do_ticks(3);
    checks++;
    if (bus.state !== 3'd3 || bus.remaining !== 4'd1 || bus.left_pending !== 2'b00) begin
      errors++;
      $display("FAIL own_during: got st=%0d rem=%0d lp=%b, want st=3 rem=1 lp=00",
               bus.state, bus.remaining, bus.left_pending);
    end
    do_tick();
    bus.left_req = 2'b00;
    checks++;
    if (bus.state !== 3'd4 || bus.remaining !== 4'd8) begin
      errors++;
      $display("FAIL own_exit: got st=%0d rem=%0d, want st=4 rem=8", bus.state, bus.remaining);
    end
    @(negedge CLOCK_50);
    checks++;
    if (bus.left_pending !== 2'b00) begin
      errors++;
      $display("FAIL own_ignored: got lp=%b, want 00", bus.left_pending);
    end
    do_ticks(23);
    checks++;
    if (bus.state !== 3'd2) begin
      errors++;
      $display("FAIL own_reach_ar: got st=%0d, want 2", bus.state);
    end
    do_tick();
    checks++;
    if (bus.state !== 3'd4 || bus.remaining !== 4'd8) begin
      errors++;
      $display("FAIL own_skip_left: got st=%0d rem=%0d, want st=4 rem=8", bus.state, bus.remaining);
    end
  endtask

  task automatic test_same_cycle();
    do_ticks(11);
    checks++;
    if (bus.state !== 3'd6 || bus.remaining !== 4'd1 || bus.left_pending !== 2'b00) begin
      errors++;
      $display("FAIL same_pre: got st=%0d rem=%0d lp=%b, want st=6 rem=1 lp=00",
               bus.state, bus.remaining, bus.left_pending);
    end
    @(negedge CLOCK_50) begin bus.tick = 1'b1; bus.left_req = 2'b01; end
    @(negedge CLOCK_50) begin bus.tick = 1'b0; bus.left_req = 2'b00; end
    checks++;
    if (bus.state !== 3'd7 || bus.remaining !== 4'd4 || bus.left_pending !== 2'b00 || bus.state_change !== 1'b1) begin
      errors++;
      $display("FAIL same_cycle_req: got st=%0d rem=%0d lp=%b sc=%b, want st=7 rem=4 lp=00 sc=1",
               bus.state, bus.remaining, bus.left_pending, bus.state_change);
    end
    do_ticks(4);
    checks++;
    if (bus.state !== 3'd0 || bus.remaining !== 4'd8) begin
      errors++;
      $display("FAIL same_ns_left_end: got st=%0d rem=%0d, want st=0 rem=8", bus.state, bus.remaining);
    end
  endtask

  task automatic test_hold();
    do_ticks(15);
    checks++;
    if (bus.state !== 3'd4 || bus.remaining !== 4'd5) begin
      errors++;
      $display("FAIL hold_pre: got st=%0d rem=%0d, want st=4 rem=5", bus.state, bus.remaining);
    end
    bus.hold = 1'b1;
    do_ticks(10);
    @(negedge CLOCK_50) bus.left_req = 2'b01;
    @(negedge CLOCK_50) bus.left_req = 2'b00;
    checks++;
    if (bus.state !== 3'd4 || bus.remaining !== 4'd5 || bus.left_pending !== 2'b01) begin
      errors++;
      $display("FAIL hold_freeze: got st=%0d rem=%0d lp=%b, want st=4 rem=5 lp=01",
               bus.state, bus.remaining, bus.left_pending);
    end
    bus.hold = 1'b0;
    do_ticks(4);
    checks++;
    if (bus.state !== 3'd4 || bus.remaining !== 4'd1) begin
      errors++;
      $display("FAIL hold_resume: got st=%0d rem=%0d, want st=4 rem=1", bus.state, bus.remaining);
    end
    do_tick();
    checks++;
    if (bus.state !== 3'd5 || bus.remaining !== 4'd3 || bus.left_pending !== 2'b01) begin
      errors++;
      $display("FAIL hold_exit: got st=%0d rem=%0d lp=%b, want st=5 rem=3 lp=01",
               bus.state, bus.remaining, bus.left_pending);
    end
  endtask

  task automatic test_reset_mid();
    do_tick();
    #3 resetn = 1'b0;
    #1;
    checks++;
    if (bus.state !== 3'd0 || bus.remaining !== 4'd8 || bus.left_pending !== 2'b00 || bus.state_change !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got st=%0d rem=%0d lp=%b sc=%b, want st=0 rem=8 lp=00 sc=0",
               bus.state, bus.remaining, bus.left_pending, bus.state_change);
    end
    @(negedge CLOCK_50) bus.tick = 1'b1;
    @(negedge CLOCK_50) begin bus.tick = 1'b0; resetn = 1'b1; end
    checks++;
    if (bus.remaining !== 4'd8) begin
      errors++;
      $display("FAIL reset_tick_ignored: got rem=%0d, want 8", bus.remaining);
    end
    do_tick();
    checks++;
    if (bus.state !== 3'd0 || bus.remaining !== 4'd7) begin
      errors++;
      $display("FAIL reset_resume: got st=%0d rem=%0d, want st=0 rem=7", bus.state, bus.remaining);
    end
  endtask

  initial begin
    test_reset();
    test_default_cycle();
    test_ew_left();
    test_own_phase();
    test_same_cycle();
    test_hold();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
